icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache between the program counter / IF stage and port A of the unified memory. It serves fetches combinationally on a hit. On a miss it raises `IStall` and refills one whole line from memory through a single-outstanding request/acknowledge handshake. It drives the `IStall` that freezes PC and IF/ID.

---
 rtl/icache_direct.sv | 144 ++++++++++++++
 tb/tb_icache_direct.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with line refill
//
// Purpose: serves instruction fetches combinationally on a hit. On a miss it
// stalls the fetch stage and refills one whole line from memory. The refill
// uses a single-outstanding request/acknowledge handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   pc_in      fetch byte address (bits [1:0] ignored)
//   req        fetch request valid
//   flush      invalidate every line
//   inst_out   fetched instruction (NOP while stalled or idle)
//   IStall     fetch not satisfied this cycle
//   mem_addr   word-aligned refill address
//   mem_req    refill read request
//   mem_rdata  refill read data, valid with mem_ack
//   mem_ack    memory accepted mem_req, mem_rdata valid
`timescale 1ns/1ps
module icache_direct #(
  parameter int          LINES = 16,
  parameter int          WORDS = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        req,
  input  logic        flush,
  output logic [31:0] inst_out,
  output logic        IStall,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int WB = $clog2(WORDS);
  localparam int OB = WB + 2;
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - OB - IB;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  // Line number (tag and index) of the line being refilled.
  logic [31-OB:0]       lline_q, lline_d;
  logic [WB-1:0]        cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic                 data_we, tag_we;

  logic [TW-1:0]        tag_q  [LINES];
  logic [31:0]          data_q [LINES*WORDS];

  logic [WB-1:0]        off;
  logic [IB-1:0]        idx;
  logic [TW-1:0]        tag;
  logic                 hit;
  logic                 last_word;
  logic                 unused_pc;

  assign off       = pc_in[OB-1:2];
  assign idx       = pc_in[OB+IB-1:OB];
  assign tag       = pc_in[31:OB+IB];
  assign unused_pc = ^pc_in[1:0];
  assign hit       = req && valid_q[idx] && (tag_q[idx] == tag);
  assign last_word = (cnt_q == WB'(WORDS - 1));

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    lline_d  = lline_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    data_we  = 1'b0;
    tag_we   = 1'b0;
    inst_out = NOP;
    IStall   = 1'b0;
    mem_req  = 1'b0;
    mem_addr = 32'h0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (hit) begin
          inst_out = data_q[{idx, off}];
        end else if (req) begin
          // Invalidate now so a partially written line can never hit.
          IStall       = 1'b1;
          lline_d      = pc_in[31:OB];
          cnt_d        = '0;
          valid_d[idx] = 1'b0;
          state_d      = REFILL;
        end
        if (flush) valid_d = '0;
      end
      REFILL: begin
        IStall   = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {lline_q, cnt_q, 2'b00};
        if (mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last_word) begin
            tag_we  = 1'b1;
            state_d = IDLE;
            drop_d  = 1'b0;
            if (!drop_q) valid_d[lline_q[IB-1:0]] = 1'b1;
          end
        end
        // A flush cannot cancel outstanding words, so it marks the line to be
        // dropped; it also overrides validation on the final ack.
        if (flush) begin
          valid_d = '0;
          drop_d  = !(mem_ack && last_word);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      lline_q <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lline_q <= lline_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Tag and data storage are gated by valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (data_we) data_q[{lline_q[IB-1:0], cnt_q}] <= mem_rdata;
    if (tag_we)  tag_q[lline_q[IB-1:0]] <= lline_q[31-OB:IB];
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct
`timescale 1ns/1ps
module tb_icache_direct;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int WORDS = 4;
  localparam int LINES = 16;

  logic        clk, rst, req, flush, mem_ack;
  logic [31:0] pc_in, mem_rdata;
  logic [31:0] inst_out, mem_addr;
  logic        IStall, mem_req;

  icache_direct #(.LINES(LINES), .WORDS(WORDS), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .req(req), .flush(flush),
    .inst_out(inst_out), .IStall(IStall), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Responder configuration and observation.
  int          slow = 0;
  int          wcnt = 0;
  logic        prev_unacked = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] acked[$];
  logic [31:0] o_inst, o_maddr;
  logic        o_stall, o_mreq;

  // Reference: which memory line each cache slot holds.
  logic        m_valid [LINES];
  int unsigned m_tag   [LINES];

  typedef struct {
    logic [31:0] pc;
    logic        rq;
    logic        exp_stall;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vt [6];

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic bit present(input logic [31:0] a);
    int unsigned i;
    i = (a / 16) % LINES;
    return m_valid[i] && (m_tag[i] == a / 256);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic tick();
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    if (mem_req) begin
      if (prev_unacked) check("addr_stable", mem_addr, prev_addr);
      if (wcnt < slow) begin
        wcnt++;
        prev_unacked = 1'b1;
        prev_addr    = mem_addr;
      end else begin
        mem_ack      = 1'b1;
        mem_rdata    = memf(mem_addr);
        acked.push_back(mem_addr);
        wcnt         = 0;
        prev_unacked = 1'b0;
      end
    end else begin
      wcnt         = 0;
      prev_unacked = 1'b0;
    end
    #1;
    o_inst  = inst_out;
    o_stall = IStall;
    o_mreq  = mem_req;
    o_maddr = mem_addr;
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int w, input string nm);
    bit          exp_hit;
    int          exp_stalls, stalls;
    bit          done;
    logic [31:0] base;
    exp_hit    = present(a);
    exp_stalls = exp_hit ? 0 : 1 + WORDS * (w + 1);
    base       = {a[31:4], 4'h0};
    pc_in = a; req = 1'b1; flush = 1'b0; slow = w;
    acked.delete();
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (o_stall) stalls++;
      else begin
        done = 1;
        check({nm, "_inst"}, o_inst, memf(a));
        check({nm, "_mreq"}, {31'h0, o_mreq}, 32'h0);
      end
    end
    check({nm, "_done"}, {31'h0, done}, 32'h1);
    check({nm, "_stalls"}, stalls, exp_stalls);
    check({nm, "_nacks"}, acked.size(), exp_hit ? 0 : WORDS);
    if (!exp_hit && acked.size() == WORDS)
      for (int k = 0; k < WORDS; k++) check({nm, "_addr"}, acked[k], base + 4 * k);
    m_valid[(a / 16) % LINES] = 1'b1;
    m_tag[(a / 16) % LINES]   = a / 256;
  endtask

  initial begin
    model_clear();
    rst = 1'b0; req = 1'b1; flush = 1'b0; pc_in = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    check("rst_stall_req1", {31'h0, IStall}, 32'h1);
    check("rst_inst", inst_out, NOP);
    check("rst_mreq", {31'h0, mem_req}, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    req = 1'b0;
    #1;
    check("rst_stall_req0", {31'h0, IStall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss then table of same-cycle probes.
    do_fetch(32'h0, 0, "cold");
    vt[0] = '{32'h8, 1'b1, 1'b0, memf(32'h8)};
    vt[1] = '{32'h4, 1'b1, 1'b0, memf(32'h4)};
    vt[2] = '{32'hC, 1'b1, 1'b0, memf(32'hC)};
    vt[3] = '{32'h9, 1'b1, 1'b0, memf(32'h8)};
    vt[4] = '{32'h0, 1'b1, 1'b0, memf(32'h0)};
    vt[5] = '{32'h4, 1'b0, 1'b0, NOP};
    for (int i = 0; i < 6; i++) begin
      pc_in = vt[i].pc; req = vt[i].rq; flush = 1'b0;
      tick();
      check($sformatf("vec%0d_stall", i), {31'h0, o_stall}, {31'h0, vt[i].exp_stall});
      check($sformatf("vec%0d_inst", i), o_inst, vt[i].exp_inst);
      check($sformatf("vec%0d_mreq", i), {31'h0, o_mreq}, 32'h0);
    end

    // Conflict eviction on index 0.
    do_fetch(32'h0, 0, "conf_a");
    do_fetch(32'h100, 0, "conf_b");
    do_fetch(32'h0, 0, "conf_c");

    // Slow memory: two wait cycles per word.
    do_fetch(32'h44, 2, "slow");
    do_fetch(32'h48, 2, "slow_hit");

    // Flush during the second refill word.
    pc_in = 32'h80; req = 1'b1; flush = 1'b0; slow = 0;
    acked.delete();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; req = 1'b0;
    tick();
    tick();
    check("flush_nacks", acked.size(), WORDS);
    tick();
    check("flush_idle_mreq", {31'h0, o_mreq}, 32'h0);
    model_clear();
    do_fetch(32'h80, 0, "flush_refetch");

    // Reset during the third refill word.
    pc_in = 32'h20; req = 1'b1; slow = 0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_mreq", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    do_fetch(32'h20, 0, "rst_refetch");

    // Randomized mix against the reference.
    for (int n = 0; n < 150; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      if (op < 7) begin
        a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
            ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        do_fetch(a, $urandom_range(0, 2), "rnd");
      end else if (op < 9) begin
        pc_in = $urandom; req = 1'b0; flush = 1'b0;
        tick();
        check("rnd_idle_stall", {31'h0, o_stall}, 32'h0);
        check("rnd_idle_inst", o_inst, NOP);
        check("rnd_idle_mreq", {31'h0, o_mreq}, 32'h0);
      end else begin
        req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
